// File: rtl/uart_baud_pkg.sv
// Shared constants and widths for the UART baud generator.
// The fractional divisor path is built only when UART_BAUD_FRAC_EN is defined.
package uart_baud_pkg;
    localparam int INT_W_DEFAULT  = 16;
    localparam int FRAC_W_DEFAULT = 4;
    localparam int OVS_DEFAULT    = 16;
    localparam int SUB_W          = $clog2(OVS_DEFAULT);
    localparam int MIN_DIV        = 2;

    typedef logic [INT_W_DEFAULT-1:0]  div_int_t;
    typedef logic [FRAC_W_DEFAULT-1:0] div_frac_t;
    typedef logic [SUB_W-1:0]          sub_t;
endpackage

// File: rtl/uart_baud_gen_chan.sv
// One baud channel: fractional down-counter, oversample tick and per-bit strobe.
// Fractional accumulator present only when UART_BAUD_FRAC_EN is defined.
module baud_chan
    import uart_baud_pkg::*;
#(
    parameter int INT_W  = INT_W_DEFAULT,
    parameter int FRAC_W = FRAC_W_DEFAULT,
    parameter int OVS    = OVS_DEFAULT,
    parameter bit MID    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              resync,
    output logic              tick,
    output logic              strobe
);
    localparam int SUB_BITS = $clog2(OVS);
    localparam logic [SUB_BITS-1:0] STROBE_AT = MID ? SUB_BITS'(OVS/2 - 1) : SUB_BITS'(OVS - 1);

    logic                active;
    logic                carry;
    logic [INT_W-1:0]    reload;
    logic [INT_W-1:0]    cnt_q, cnt_d;
    logic [SUB_BITS-1:0] sub_q, sub_d;
    logic                tick_q, tick_d;
    logic                strobe_q, strobe_d;

    assign active = en && (div_int >= INT_W'(MIN_DIV));
    // P-1 with P = div_int + carry; a carry on all-ones still fits in INT_W
    assign reload = carry ? div_int : div_int - INT_W'(1);

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc_q, acc_d, acc_sum;

    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, div_frac};

    always_comb begin
        acc_d = acc_q;
        if (!active || resync) acc_d = '0;
        else if (cnt_q == '0)  acc_d = acc_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end
`else
    logic unused_frac;
    assign unused_frac = ^div_frac;
    assign carry       = 1'b0;
`endif

    always_comb begin
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        tick_d   = 1'b0;
        strobe_d = 1'b0;
        if (!active || resync) begin
            // resync beats a coincident tick
            cnt_d = '0;
            sub_d = '0;
        end else begin
            if (cnt_q == '0) cnt_d = reload;
            else             cnt_d = cnt_q - INT_W'(1);
            tick_d = (cnt_q == INT_W'(1));
            if (tick_d) begin
                sub_d    = sub_q + SUB_BITS'(1);
                strobe_d = (sub_q == STROBE_AT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            sub_q    <= '0;
            tick_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            tick_q   <= tick_d;
            strobe_q <= strobe_d;
        end
    end

    assign tick   = tick_q;
    assign strobe = strobe_q;
endmodule

// File: rtl/uart_baud_gen.sv
// Dual-channel UART baud generator: RX strobes mid-bit, TX strobes at bit boundary.
// Define UART_BAUD_FRAC_EN to enable the fractional divisors.
module uart_baud_gen
    import uart_baud_pkg::*;
#(
    parameter int INT_W  = INT_W_DEFAULT,
    parameter int FRAC_W = FRAC_W_DEFAULT,
    parameter int OVS    = OVS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [INT_W-1:0]  div_rx_int,
    input  logic [FRAC_W-1:0] div_rx_frac,
    input  logic [INT_W-1:0]  div_tx_int,
    input  logic [FRAC_W-1:0] div_tx_frac,
    input  logic              rx_resync,
    output logic              tick_rx,
    output logic              tick_tx,
    output logic              bit_rx,
    output logic              bit_tx
);
    baud_chan #(.INT_W(INT_W), .FRAC_W(FRAC_W), .OVS(OVS), .MID(1'b1)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_int  (div_rx_int),
        .div_frac (div_rx_frac),
        .resync   (rx_resync),
        .tick     (tick_rx),
        .strobe   (bit_rx)
    );

    baud_chan #(.INT_W(INT_W), .FRAC_W(FRAC_W), .OVS(OVS), .MID(1'b0)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_int  (div_tx_int),
        .div_frac (div_tx_frac),
        .resync   (1'b0),
        .tick     (tick_tx),
        .strobe   (bit_tx)
    );
endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: event timestamps checked against a scoreboard
// of expected cycle offsets. Honours UART_BAUD_FRAC_EN for the fractional cases.
module tb_uart_baud_gen;
    import uart_baud_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      en;
    div_int_t  div_rx_int, div_tx_int;
    div_frac_t div_rx_frac, div_tx_frac;
    logic      rx_resync;
    logic      tick_rx, tick_tx, bit_rx, bit_tx;

    uart_baud_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .div_rx_int  (div_rx_int),
        .div_rx_frac (div_rx_frac),
        .div_tx_int  (div_tx_int),
        .div_tx_frac (div_tx_frac),
        .rx_resync   (rx_resync),
        .tick_rx     (tick_rx),
        .tick_tx     (tick_tx),
        .bit_rx      (bit_rx),
        .bit_tx      (bit_tx)
    );

    always #5 clk = ~clk;

    // Event log: cycle stamps taken at each negedge
    int cyc = 0;
    int tt_q[$], tr_q[$], bt_q[$], br_q[$];
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tick_tx) tt_q.push_back(cyc);
        if (tick_rx) tr_q.push_back(cyc);
        if (bit_tx)  bt_q.push_back(cyc);
        if (bit_rx)  br_q.push_back(cyc);
    end

    int exp_q[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic push_exp(input int v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input int obs);
        int e;
        n_chk++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -12345;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
        end
    endtask

    function automatic int ev(input int which, input int i);
        int r;
        r = -1000000;
        case (which)
            0: if (i < tt_q.size()) r = tt_q[i];
            1: if (i < tr_q.size()) r = tr_q[i];
            2: if (i < bt_q.size()) r = bt_q[i];
            default: if (i < br_q.size()) r = br_q[i];
        endcase
        return r;
    endfunction

    // Cycle offset of the k-th tick after the first active edge (k from 1)
    function automatic int tick_at(input int d, input int f, input int k);
        int acc, t, p;
        acc = 0;
        t   = 0;
        for (int i = 0; i < k; i++) begin
            p = d;
`ifdef UART_BAUD_FRAC_EN
            acc = acc + f;
            if (acc >= 16) begin
                acc = acc - 16;
                p   = d + 1;
            end
`endif
            t = t + p;
        end
        return t;
    endfunction

    task automatic clear_log();
        tt_q.delete();
        tr_q.delete();
        bt_q.delete();
        br_q.delete();
    endtask

    // Inputs change #1 after a negedge; the following posedge is the first edge to see them
    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({tick_rx, tick_tx, bit_rx, bit_tx});
    endfunction

    int c0, cr;

    initial begin
        rst = 1'b0; en = 1'b1; rx_resync = 1'b0;
        div_tx_int = 16'd10; div_tx_frac = 4'd0;
        div_rx_int = 16'd10; div_rx_frac = 4'd8;
        push_exp(0);
        run(3);
        check("reset_outs", outs());

        // Release from reset: TX /10, RX /10 + 8/16
        rst = 1'b1;
        c0  = cyc;
        clear_log();
        push_exp(10); push_exp(10); push_exp(160); push_exp(160);
        push_exp(tick_at(10, 8, 2) - tick_at(10, 8, 1));
        push_exp(tick_at(10, 8, 17) - tick_at(10, 8, 1));
        push_exp(tick_at(10, 8, 8));
        run(340);
        check("tx_first_tick", ev(0, 0) - c0);
        check("tx_tick_period", ev(0, 5) - ev(0, 4));
        check("tx_first_bit", ev(2, 0) - c0);
        check("tx_bit_period", ev(2, 1) - ev(2, 0));
        check("rx_frac_period", ev(1, 1) - ev(1, 0));
        check("rx_16tick_span", ev(1, 16) - ev(1, 0));
        check("rx_first_bit", ev(3, 0) - c0);

        // Divisor below minimum: TX silent
        div_tx_int = 16'd1;
        clear_log();
        push_exp(0);
        run(1000);
        check("tx_div1_silent", tt_q.size() + bt_q.size());

        // Back to /4: restarts from zero state
        div_tx_int = 16'd4;
        c0 = cyc;
        clear_log();
        push_exp(4); push_exp(4);
        run(20);
        check("tx_div4_first", ev(0, 0) - c0);
        check("tx_div4_period", ev(0, 1) - ev(0, 0));

        // Maximum rate
        div_tx_int = 16'd2;
        clear_log();
        push_exp(2);
        run(20);
        check("tx_div2_period", ev(0, 5) - ev(0, 4));

        // Global disable
        en = 1'b0;
        clear_log();
        push_exp(0);
        run(1000);
        check("en0_silent", tt_q.size() + tr_q.size() + bt_q.size() + br_q.size());

        // RX resync mid-period
        div_rx_int = 16'd8; div_rx_frac = 4'd0; div_tx_int = 16'd10;
        en = 1'b1;
        run(20);
        rx_resync = 1'b1;
        cr = cyc;
        push_exp(0); push_exp(65); push_exp(128);
        run(1);
        rx_resync = 1'b0;
        check("resync_tick_low", int'(tick_rx));
        clear_log();
        run(300);
        check("resync_first_bit", ev(3, 0) - cr);
        check("resync_bit_period", ev(3, 1) - ev(3, 0));

        // Resync landing on a tick edge
        en = 1'b0;
        run(1);
        en = 1'b1;
        c0 = cyc;
        run(23);
        rx_resync = 1'b1;
        push_exp(0); push_exp(8); push_exp(64);
        run(1);
        rx_resync = 1'b0;
        check("coinc_tick_supp", int'(tick_rx));
        c0 = cyc;
        clear_log();
        run(200);
        check("coinc_first_tick", ev(1, 0) - c0);
        check("coinc_first_bit", ev(3, 0) - c0);

        // Divisor change mid-period takes effect at the next load
        en = 1'b0;
        run(1);
        en = 1'b1;
        c0 = cyc;
        run(15);
        div_tx_int = 16'd20;
        clear_log();
        push_exp(20); push_exp(40);
        run(50);
        check("chg_cur_period", ev(0, 0) - c0);
        check("chg_next_period", ev(0, 1) - c0);

        // Reset mid-period, then restart
        rst = 1'b0;
        push_exp(0);
        run(1);
        check("midrst_outs", outs());
        div_tx_int = 16'd10;
        rst = 1'b1;
        c0  = cyc;
        clear_log();
        push_exp(10); push_exp(10);
        run(30);
        check("restart_first_tick", ev(0, 0) - c0);
        check("restart_period", ev(0, 1) - ev(0, 0));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
